object_collider: RTL
====================

# object_collider

Consumer of the packed object records produced by the player/title updater and the obstacle generators. Once per game tick, `object_collider` snapshots the player record and accepts obstacle records one at a time over a valid/ready stream. It tests each obstacle for axis-aligned box overlap with the player and reports a frame-done pulse plus a sticky collision (game-over) flag. It sits between the object-update blocks and the game-state controller.

## Interface
- `MAXOBJ`, default 8: maximum obstacle records per frame. Index width `IW = $clog2(MAXOBJ)`.
- `EMPTY_TYPE`, default 0: type code marking an unused record slot. Such records are accepted but never hit.
- `clk3`  in  1  game clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  game running. When low, ticks are ignored and any scan aborts.
- `pause`  in  1  stalls the scan.
- `tick`  in  1  one-cycle frame-start pulse.
- `player`  in  `datalen`  packed player record. Fields are at `datatypestart`, `dataxstart`, `dataystart`, `datawidthstart`, `dataheightstart`.
- `obj_data`  in  `datalen`  obstacle record, same packing.
- `obj_valid`  in  1  `obj_data` is valid.
- `obj_last`  in  1  last record of the frame, qualified by `obj_valid`.
- `obj_ready`  out  1  collider accepts a record this cycle.
- `done`  out  1  one-cycle pulse at frame end.
- `collide`  out  1  sticky collision flag, cleared only by reset.
- `hit_index`  out  IW  index of the first colliding record in the most recent frame that contained a hit.
- `overrun`  out  1  sticky flag: a tick arrived while not IDLE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE → SCAN:
  - Condition: `tick && start && !collide`.
  - Actions: latch `player` into a snapshot register; clear index counter and frame-hit flag.
- SCAN:
  - `obj_ready = !pause && start`.
  - On accept (`obj_valid && obj_ready`): evaluate the record, then increment the index.
  - Go to DONE on accept of a record with `obj_last`, or on accept of record index MAXOBJ-1.
- Hit condition (all must hold):
  - snapshot type == `playertype`;
  - obstacle type != EMPTY_TYPE;
  - px < ox+ow and ox < px+pw and py < oy+oh and oy < py+ph.
- Overlap arithmetic:
  - Sums use one extra bit, so there is no wrap-around.
  - Comparisons are unsigned and strict: touching edges is not a hit; zero width or height never hits.
- First hit of a frame: set the frame-hit flag and record `hit_index`. Later hits in the same frame do not change `hit_index`.
- DONE:
  - `done = 1` for one cycle.
  - `collide |= frame_hit`.
  - Next state is IDLE.
- `start` low in SCAN: go to IDLE immediately. No `done` pulse; `collide` and `hit_index` unchanged.
- `tick` while in SCAN or DONE: ignored for scan control, and sets `overrun`.
- Once `collide = 1`, ticks are ignored. The block stays in IDLE until reset.
- Reset (any state, mid-scan included):
  - state IDLE;
  - `obj_ready`, `done`, `collide`, `overrun` = 0;
  - `hit_index` = 0;
  - index counter and snapshot = 0.

## Timing
- `tick` sampled high at edge 0 → SCAN from edge 1, with `obj_ready` high from cycle 1.
- N back-to-back records are accepted at edges 1..N. `done` is high during cycle N+1, and `collide` is updated on that same edge.
- Throughput: one record per cycle. Minimum tick spacing without overrun is N+2 cycles.
- `obj_ready` is a registered state decode ANDed combinationally with `!pause && start`.
- `pause` high holds the index and state. No record is accepted while paused; records are evaluated only on accept.
- `obj_last` and index MAXOBJ-1 on the same accept: a single transition to DONE.
- The player record is sampled only at the IDLE→SCAN edge. Changes during SCAN are ignored.

## Test plan
- Player type `playertype`, x=20 y=50 w=10 h=10; one obstacle x=25 y=55 w=5 h=5 with `obj_last`; tick at cycle 0. Required: accept at cycle 1, `done`=1 and `collide`=1 at cycle 2, `hit_index`=0.
- Same player; obstacle x=30 y=50 w=5 h=10 (touching edge). Required: `done` pulse, `collide` stays 0.
- 3 records: index 0 misses; index 1 (x=22, type EMPTY_TYPE) overlaps; index 2 (x=28) overlaps with `obj_last`. Required: `done` at cycle 4, `collide`=1, `hit_index`=2.
- `pause` held high cycles 2-4 during a 3-record scan. Required: `obj_ready`=0 in cycles 2-4, no accepts, and `done` delayed by exactly 3 cycles.
- Second `tick` at cycle 2 of a scan. Required: `overrun`=1, scan completes normally, one `done` pulse only.
- `reset` low for one edge mid-scan after a hit record was accepted. Required: all outputs 0 next cycle, IDLE, and the next tick starts a fresh scan. Separately: `start` dropped mid-scan → no `done` pulse.

Source files
------------

// File: rtl/object_collider.sv
// Per-tick box-overlap test of a snapshotted player record against a stream of
// obstacle records; reports a frame-done pulse and a sticky game-over flag.
module object_collider #(
    parameter int unsigned MAXOBJ          = 8,
    parameter int unsigned EMPTY_TYPE      = 0,
    parameter int unsigned playertype      = 1,
    parameter int unsigned typelen         = 4,
    parameter int unsigned coordlen        = 10,
    parameter int unsigned datatypestart   = 0,
    parameter int unsigned dataxstart      = 4,
    parameter int unsigned dataystart      = 14,
    parameter int unsigned datawidthstart  = 24,
    parameter int unsigned dataheightstart = 34,
    parameter int unsigned datalen         = 44,
    localparam int unsigned IW = (MAXOBJ > 1) ? $clog2(MAXOBJ) : 1
) (
    input  logic               clk3,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               tick,
    input  logic [datalen-1:0] player,
    input  logic [datalen-1:0] obj_data,
    input  logic               obj_valid,
    input  logic               obj_last,
    output logic               obj_ready,
    output logic               done,
    output logic               collide,
    output logic [IW-1:0]      hit_index,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [datalen-1:0] snap;
    logic [IW-1:0]      idx;
    logic               frame_hit;
    logic [IW-1:0]      frame_idx;
    logic               take;
    logic               take_last;
    logic               obj_hit;

    logic [typelen-1:0]  p_type, o_type;
    logic [coordlen-1:0] px, py, pw, ph, ox, oy, ow, oh;
    logic [coordlen:0]   px_end, py_end, ox_end, oy_end;

    assign p_type = snap[datatypestart +: typelen];
    assign px     = snap[dataxstart +: coordlen];
    assign py     = snap[dataystart +: coordlen];
    assign pw     = snap[datawidthstart +: coordlen];
    assign ph     = snap[dataheightstart +: coordlen];
    assign o_type = obj_data[datatypestart +: typelen];
    assign ox     = obj_data[dataxstart +: coordlen];
    assign oy     = obj_data[dataystart +: coordlen];
    assign ow     = obj_data[datawidthstart +: coordlen];
    assign oh     = obj_data[dataheightstart +: coordlen];

    // Far edges carry one extra bit so boxes near the top of the field never wrap
    assign px_end = {1'b0, px} + {1'b0, pw};
    assign py_end = {1'b0, py} + {1'b0, ph};
    assign ox_end = {1'b0, ox} + {1'b0, ow};
    assign oy_end = {1'b0, oy} + {1'b0, oh};

    assign obj_hit = (p_type == typelen'(playertype))
                  && (o_type != typelen'(EMPTY_TYPE))
                  && ({1'b0, px} < ox_end) && ({1'b0, ox} < px_end)
                  && ({1'b0, py} < oy_end) && ({1'b0, oy} < py_end);

    always_ff @(posedge clk3) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (tick && start && !collide) state_nxt = SCAN;
            SCAN: begin
                if (!start) begin
                    state_nxt = IDLE;
                end else if (take_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        obj_ready = 1'b0;
        done      = 1'b0;
        take      = 1'b0;
        take_last = 1'b0;
        obj_ready = (state == SCAN) && !pause && start;
        done      = (state == DONE);
        take      = obj_valid && obj_ready;
        take_last = take && (obj_last || (idx == IW'(MAXOBJ - 1)));
    end

    // Frame bookkeeping; results are committed only when the frame completes
    always_ff @(posedge clk3) begin
        if (!reset) begin
            snap      <= '0;
            idx       <= '0;
            frame_hit <= 1'b0;
            frame_idx <= '0;
            collide   <= 1'b0;
            hit_index <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == SCAN) begin
                snap      <= player;
                idx       <= '0;
                frame_hit <= 1'b0;
                frame_idx <= '0;
            end
            if (take) begin
                idx <= idx + IW'(1);
                if (obj_hit && !frame_hit) begin
                    frame_hit <= 1'b1;
                    frame_idx <= idx;
                end
                if (take_last && (frame_hit || obj_hit)) begin
                    collide   <= 1'b1;
                    hit_index <= frame_hit ? frame_idx : idx;
                end
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
